// File: rtl/canny_pkg.sv
// Shared types and sizing helpers for the Canny frame-level control path.
package canny_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    localparam int unsigned DEF_IMG_W  = 640;
    localparam int unsigned DEF_IMG_H  = 480;
    localparam int unsigned DEF_ADDR_W = 11;

    // Pipeline latency in beats: whole buffered lines plus the extra pixel taps.
    function automatic int unsigned lat_of(input int unsigned img_w,
                                           input int unsigned lat_rows,
                                           input int unsigned lat_cols);
        return lat_rows * img_w + lat_cols;
    endfunction

endpackage

// File: rtl/pos_counter.sv
// Column/row position counter; advances on en_i, wrap_o flags the last column of a line.
module pos_counter #(
    parameter int unsigned NCOL  = 8,
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             wrap_o
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOL - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign wrap_o = en_i & (col_q == COL_LAST);
    assign col_o  = col_q;
    assign row_o  = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny pipeline: input handshake, line-buffer addressing,
// drain padding after the last pixel and latency-aligned output framing.
module canny_frame_ctrl
    import canny_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NLB      = 4,
    parameter int unsigned LAT_ROWS = 2,
    parameter int unsigned LAT_COLS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic                   out_ready,
    output logic                   in_ready,
    output logic                   pipe_en,
    output logic                   pad,
    output logic [ADDR_W-1:0]      lb_addr,
    output logic [$clog2(NLB)-1:0] lb_wsel,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   busy
);
    localparam int unsigned LAT     = lat_of(IMG_W, LAT_ROWS, LAT_COLS);
    localparam int unsigned ROW_W   = $clog2(IMG_H + LAT_ROWS + 1);
    localparam int unsigned BEAT_W  = $clog2(IMG_W * IMG_H + LAT + 1);
    localparam int unsigned FLUSH_W = $clog2(LAT + 1);
    localparam int unsigned WSEL_W  = $clog2(NLB);

    localparam logic [ADDR_W-1:0]  COL_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAT   = BEAT_W'(LAT);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(LAT - 1);
    localparam logic [WSEL_W-1:0]  WSEL_LAST  = WSEL_W'(NLB - 1);

    ctrl_state_t        state_q, state_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WSEL_W-1:0]  wsel_q, wsel_d;
    logic               frame_err_q, frame_err_d;
    logic               frame_done_q;

    logic [ADDR_W-1:0]  col;
    logic [ROW_W-1:0]   row;
    logic               col_wrap;
    logic               at_final;
    logic               flush_last;
    logic               err_set;

    pos_counter #(
        .NCOL  (IMG_W),
        .COL_W (ADDR_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (pipe_en),
        .clr_i  (flush_last),
        .col_o  (col),
        .row_o  (row),
        .wrap_o (col_wrap)
    );

    assign at_final = (row == ROW_LAST) && (col == COL_LAST);

    // Early and missing in_last both end the input phase; only the error flag differs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        pipe_en    = 1'b0;
        pad        = 1'b0;
        flush_last = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                in_ready = out_ready;
                pipe_en  = in_valid & out_ready;
                if (pipe_en && (in_last || at_final)) begin
                    state_d = FLUSH;
                    err_set = in_last ^ at_final;
                end
            end
            FLUSH: begin
                pad     = 1'b1;
                pipe_en = out_ready;
                if (pipe_en && (flush_cnt_q == FLUSH_LAST)) begin
                    flush_last = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = pipe_en & (beat_cnt_q >= BEAT_LAT);
    assign out_last  = out_valid & flush_last;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wsel_d      = wsel_q;
        frame_err_d = frame_err_q;
        if (flush_last) begin
            beat_cnt_d  = '0;
            flush_cnt_d = '0;
        end else if (pipe_en) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            if (state_q == FLUSH) flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
        // Rotation survives across frames; the datapath only uses relative line offsets.
        if (col_wrap) wsel_d = (wsel_q == WSEL_LAST) ? '0 : wsel_q + WSEL_W'(1);
        if (state_q == IDLE && in_valid) frame_err_d = 1'b0;
        else if (err_set)                frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            wsel_q       <= '0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            wsel_q       <= wsel_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= flush_last;
        end
    end

    assign lb_addr    = col;
    assign lb_wsel    = wsel_q;
    assign frame_err  = frame_err_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Randomized frame-level bench for canny_frame_ctrl against a beat-index reference model.
module tb_canny_frame_ctrl;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 3;
    localparam int NLB = 4;
    localparam int LR  = 2;
    localparam int LC  = 3;
    localparam int LAT = LR * W + LC;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic in_ready, pipe_en, pad, out_valid, out_last, frame_done, frame_err, busy;
    logic [AW-1:0] lb_addr;
    logic [1:0]    lb_wsel;

    int total = 0;
    int bad = 0;
    int wsel0 = 0;
    int prev_err = 0;

    always #5 clk = ~clk;

    canny_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .NLB(NLB), .LAT_ROWS(LR), .LAT_COLS(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .out_ready(out_ready), .in_ready(in_ready), .pipe_en(pipe_en), .pad(pad),
        .lb_addr(lb_addr), .lb_wsel(lb_wsel), .out_valid(out_valid), .out_last(out_last),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_pipe_en", int'(pipe_en), 0);
        check("rst_pad", int'(pad), 0);
        check("rst_lb_addr", int'(lb_addr), 0);
        check("rst_lb_wsel", int'(lb_wsel), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
    endtask

    // n_last: beat index carrying in_last (0 = never). rmode: 0 ready=1, 1 toggle, 2 random.
    // vmode: random input gaps. abort_at: assert reset before this beat (0 = never).
    task automatic run_frame(input int n_last, input int rmode, input int vmode, input int abort_at);
        int n, t, k, cyc, nvalid, nlast, exp_err, pe_exp;
        logic ordy, iv, in_run;
        n = (n_last >= 1 && n_last <= NPIX) ? n_last : NPIX;
        t = n + LAT;
        exp_err = (n_last == NPIX) ? 0 : 1;
        k = 1; cyc = 0; nvalid = 0; nlast = 0;

        // idle cycle: request start
        @(negedge clk);
        in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        #1;
        check("idle_busy", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_pipe_en", int'(pipe_en), 0);
        check("idle_frame_done", int'(frame_done), 0);
        check("idle_frame_err", int'(frame_err), prev_err);
        check("idle_lb_addr", int'(lb_addr), 0);
        @(posedge clk);

        while (k <= t) begin
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin
                check("frame_timeout", k, t + 1);
                return;
            end
            if (abort_at != 0 && k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals();
                in_valid = 1'b0; in_last = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                wsel0 = 0;
                prev_err = 0;
                return;
            end
            in_run = (k <= n);
            case (rmode)
                0: ordy = 1'b1;
                1: ordy = cyc[0];
                default: ordy = ($urandom_range(0, 2) != 0);
            endcase
            iv = in_run ? (vmode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
            out_ready = ordy;
            in_valid = iv;
            in_last = iv && (k == n_last);
            #1;
            pe_exp = in_run ? int'(iv & ordy) : int'(ordy);
            check("busy", int'(busy), 1);
            check("in_ready", int'(in_ready), in_run ? int'(ordy) : 0);
            check("pipe_en", int'(pipe_en), pe_exp);
            check("pad", int'(pad), in_run ? 0 : 1);
            check("lb_addr", int'(lb_addr), (k - 1) % W);
            check("lb_wsel", int'(lb_wsel), (wsel0 + (k - 1) / W) % NLB);
            check("out_valid", int'(out_valid), (pe_exp != 0 && k > LAT) ? 1 : 0);
            check("out_last", int'(out_last), (pe_exp != 0 && k == t) ? 1 : 0);
            if (k > n + 1 || (k == n + 1 && n_last != 0)) check("frame_err_mid", int'(frame_err), exp_err);
            if (out_valid) nvalid++;
            if (out_last) nlast++;
            @(posedge clk);
            if (pe_exp != 0) k++;
        end

        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        check("frame_done_pulse", int'(frame_done), 1);
        check("end_busy", int'(busy), 0);
        check("end_frame_err", int'(frame_err), exp_err);
        check("out_valid_count", nvalid, n);
        check("out_last_count", nlast, 1);
        @(negedge clk);
        #1;
        check("frame_done_single", int'(frame_done), 0);
        wsel0 = (wsel0 + t / W) % NLB;
        prev_err = exp_err;
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(NPIX, 0, 0, 0);          // nominal
        run_frame(NPIX, 1, 0, 0);          // backpressure 1010...
        run_frame(10, 2, 0, 0);            // early last
        run_frame(0, 2, 1, 0);             // missing last
        run_frame(NPIX, 2, 1, 0);          // error clears on next start
        run_frame(NPIX, 0, 0, 15);         // reset mid-frame
        run_frame(NPIX, 0, 0, 0);          // clean frame after abort
        for (int i = 0; i < 6; i++) begin
            int sel, nl;
            sel = int'($urandom_range(0, 2));
            nl = (sel == 0) ? NPIX : (sel == 1) ? 0 : int'($urandom_range(1, NPIX - 1));
            run_frame(nl, 2, int'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
